// File: rtl/common_pkg.sv
// Shared CLIC types: priority/index widths and per-entry vector types.
// Entry index '1 is reserved for the current threshold.
package common_pkg;
  localparam int unsigned NR_PRIO_BITS  = 3;
  localparam int unsigned NR_INDEX_BITS = 3;
  localparam int unsigned NR_ENTRIES    = 2**NR_INDEX_BITS;

  typedef logic [NR_PRIO_BITS-1:0]  Prio;
  typedef logic [NR_INDEX_BITS-1:0] Index;
  typedef Prio [NR_ENTRIES-1:0]     PrioEntries;
  typedef logic [NR_ENTRIES-1:0]    BitEntries;
endpackage

// File: rtl/can_clic_nest.sv
// can_clic_nest: nesting controller around the combinational can_clic arbiter.
// Holds pend bits and the current threshold, presents the arbiter winner to
// the core as a registered req/ack handshake, and keeps a stack of preempted
// thresholds for nested handlers.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   prio_cfg/enable_cfg per-source config (slot '1 ignored)
//   pend_set            one-cycle pend set pulses (slot '1 ignored)
//   arb_entries/enable/pend  to arbiter, slot '1 carries the threshold
//   arb_is_interrupt/arb_index  arbiter result
//   irq_req/irq_index   registered request to core
//   irq_ack/irq_ret     core accepts request / leaves handler
//   threshold, depth    current threshold and stack occupancy
//   err_ovf/unf/proto   sticky error flags
module can_clic_nest
  import common_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = 2**NR_PRIO_BITS,
  localparam int unsigned DW = $clog2(STACK_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  PrioEntries      prio_cfg,
  input  BitEntries       enable_cfg,
  input  BitEntries       pend_set,
  output PrioEntries      arb_entries,
  output BitEntries       arb_enable,
  output BitEntries       arb_pend,
  input  logic            arb_is_interrupt,
  input  Index            arb_index,
  output logic            irq_req,
  output Index            irq_index,
  input  logic            irq_ack,
  input  logic            irq_ret,
  output Prio             threshold,
  output logic [DW-1:0]   depth,
  output logic            err_ovf,
  output logic            err_unf,
  output logic            err_proto
);

  localparam Index THR_SLOT = '1;
  localparam int unsigned SW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic {IDLE, REQ} state_e;

  state_e          state_q;
  BitEntries       pend_q, pend_d, clr_d;
  Prio             thr_q, thr_d;
  logic [DW-1:0]   depth_q, depth_d;
  logic            req_q;
  Index            idx_q;
  logic            ovf_q, unf_q, proto_q;
  Prio             stack_q [STACK_DEPTH];

  logic            ack_ok, ret_ok, full, empty;
  logic [SW-1:0]   push_ptr, pop_ptr;

  always_comb begin
    ack_ok   = irq_ack & req_q;
    // A return coinciding with any ack is discarded (protocol error).
    ret_ok   = irq_ret & ~irq_ack;
    full     = (depth_q == DW'(STACK_DEPTH));
    empty    = (depth_q == '0);
    push_ptr = SW'(depth_q);
    pop_ptr  = SW'(depth_q - DW'(1));

    clr_d = '0;
    if (ack_ok) clr_d[idx_q] = 1'b1;
    // Set is ORed after the clear so a same-cycle set survives.
    pend_d = (pend_q & ~clr_d) | pend_set;
    pend_d[THR_SLOT] = 1'b0;

    thr_d   = thr_q;
    depth_d = depth_q;
    if (ack_ok) begin
      thr_d = prio_cfg[idx_q];
      if (!full) depth_d = depth_q + DW'(1);
    end else if (ret_ok && !empty) begin
      thr_d   = stack_q[pop_ptr];
      depth_d = depth_q - DW'(1);
    end
  end

  always_comb begin
    arb_entries           = prio_cfg;
    arb_entries[THR_SLOT] = thr_q;
    arb_enable            = enable_cfg;
    arb_enable[THR_SLOT]  = 1'b1;
    arb_pend              = pend_q;
    arb_pend[THR_SLOT]    = 1'b1;
  end

  // Stack contents need no reset; only depth_q qualifies them.
  always_ff @(posedge clk) begin
    if (ack_ok && !full) stack_q[push_ptr] <= thr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      thr_q   <= '0;
      depth_q <= '0;
      req_q   <= 1'b0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      proto_q <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      thr_q   <= thr_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_q | (ack_ok & full);
      unf_q   <= unf_q | (ret_ok & empty);
      proto_q <= proto_q | (irq_ack & (~req_q | irq_ret));
      case (state_q)
        IDLE: begin
          if (arb_is_interrupt) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            idx_q   <= arb_index;
          end
        end
        REQ: begin
          if (ack_ok || !arb_is_interrupt) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
          end else begin
            idx_q <= arb_index;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign irq_req   = req_q;
  assign irq_index = idx_q;
  assign threshold = thr_q;
  assign depth     = depth_q;
  assign err_ovf   = ovf_q;
  assign err_unf   = unf_q;
  assign err_proto = proto_q;

endmodule

// File: tb/tb_can_clic_nest.sv
// Directed bench for can_clic_nest with a behavioural arbiter model:
// highest priority among enabled+pending entries, higher index wins ties,
// so threshold slot 7 wins ties; interrupt only when slot 7 does not win.
module tb_can_clic_nest;
  import common_pkg::*;

  logic       clk, rst_n;
  PrioEntries prio_cfg, arb_entries;
  BitEntries  enable_cfg, pend_set, arb_enable, arb_pend;
  logic       arb_is_interrupt;
  Index       arb_index;
  logic       irq_req;
  Index       irq_index;
  logic       irq_ack, irq_ret;
  Prio        threshold;
  logic [1:0] depth;
  logic       err_ovf, err_unf, err_proto;

  int checks = 0;
  int failures = 0;

  can_clic_nest #(.STACK_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .prio_cfg(prio_cfg), .enable_cfg(enable_cfg), .pend_set(pend_set),
    .arb_entries(arb_entries), .arb_enable(arb_enable), .arb_pend(arb_pend),
    .arb_is_interrupt(arb_is_interrupt), .arb_index(arb_index),
    .irq_req(irq_req), .irq_index(irq_index),
    .irq_ack(irq_ack), .irq_ret(irq_ret),
    .threshold(threshold), .depth(depth),
    .err_ovf(err_ovf), .err_unf(err_unf), .err_proto(err_proto)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    Prio  bp;
    Index bi;
    logic found;
    bp = '0; bi = '0; found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (arb_enable[i] && arb_pend[i] && (!found || arb_entries[i] >= bp)) begin
        found = 1'b1;
        bp = arb_entries[i];
        bi = Index'(i);
      end
    end
    arb_index = bi;
    arb_is_interrupt = found && (bi != 3'd7);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_pend(input int src);
    pend_set[src] = 1'b1;
    tick();
    pend_set = '0;
  endtask

  task automatic do_ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic do_ret();
    irq_ret = 1'b1;
    tick();
    irq_ret = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    prio_cfg = '0; enable_cfg = '0; pend_set = '0;
    irq_ack = 1'b0; irq_ret = 1'b0;
    tick(); tick();
    check("rst_req", 32'(irq_req), 0);
    check("rst_idx", 32'(irq_index), 0);
    check("rst_thr", 32'(threshold), 0);
    check("rst_depth", 32'(depth), 0);
    check("rst_errs", 32'({err_ovf, err_unf, err_proto}), 0);
    check("rst_arb_pend", 32'(arb_pend), 32'h80);
    check("rst_arb_en", 32'(arb_enable), 32'h80);
    @(negedge clk);
    rst_n = 1'b1;

    prio_cfg[1] = 3'd3; enable_cfg[1] = 1'b1;
    prio_cfg[2] = 3'd3; enable_cfg[2] = 1'b1;
    prio_cfg[4] = 3'd6; enable_cfg[4] = 1'b1;
    prio_cfg[5] = 3'd5; enable_cfg[5] = 1'b1;
    tick();

    // Single source
    pulse_pend(2);
    check("t1_latency_req", 32'(irq_req), 0);
    tick();
    check("t1_req", 32'(irq_req), 1);
    check("t1_idx", 32'(irq_index), 2);
    do_ack();
    check("t1_pend2", 32'(arb_pend[2]), 0);
    check("t1_thr", 32'(threshold), 3);
    check("t1_depth", 32'(depth), 1);
    check("t1_req_off", 32'(irq_req), 0);
    check("t1_arb_thr", 32'(arb_entries[7]), 3);

    // Preemption
    pulse_pend(5);
    tick();
    check("t2_req", 32'(irq_req), 1);
    check("t2_idx", 32'(irq_index), 5);
    do_ack();
    check("t2_thr", 32'(threshold), 5);
    check("t2_depth", 32'(depth), 2);
    do_ret();
    check("t2_ret_thr", 32'(threshold), 3);
    check("t2_ret_depth", 32'(depth), 1);

    // Equal priority does not preempt
    pulse_pend(1);
    tick(); tick();
    check("t3_no_req", 32'(irq_req), 0);
    do_ret();
    check("t3_thr0", 32'(threshold), 0);
    check("t3_depth0", 32'(depth), 0);
    check("t3_req_wait", 32'(irq_req), 0);
    tick();
    check("t3_req", 32'(irq_req), 1);
    check("t3_idx", 32'(irq_index), 1);
    do_ack();
    check("t3_thr", 32'(threshold), 3);
    check("t3_pend1", 32'(arb_pend[1]), 0);
    do_ret();
    check("t3_ret_thr", 32'(threshold), 0);

    // Tracking and withdrawal
    pulse_pend(2);
    tick();
    check("t4_idx2", 32'(irq_index), 2);
    pulse_pend(4);
    check("t4_idx_old", 32'(irq_index), 2);
    tick();
    check("t4_req", 32'(irq_req), 1);
    check("t4_idx4", 32'(irq_index), 4);
    enable_cfg[4] = 1'b0; enable_cfg[2] = 1'b0;
    tick();
    check("t4_withdraw", 32'(irq_req), 0);
    tick();
    check("t4_idle", 32'(irq_req), 0);
    enable_cfg[4] = 1'b1; enable_cfg[2] = 1'b1;
    tick();
    check("t4_reidx", 32'(irq_index), 4);
    do_ack();
    check("t4_thr", 32'(threshold), 6);
    tick();
    check("t4_masked2", 32'(irq_req), 0);
    do_ret();
    check("t4_thr0", 32'(threshold), 0);
    tick();
    check("t4_idx2b", 32'(irq_index), 2);

    // Ack and ret in the same cycle
    irq_ack = 1'b1; irq_ret = 1'b1;
    tick();
    irq_ack = 1'b0; irq_ret = 1'b0;
    check("ar_proto", 32'(err_proto), 1);
    check("ar_depth", 32'(depth), 1);
    check("ar_thr", 32'(threshold), 3);
    check("ar_unf", 32'(err_unf), 0);
    do_ret();
    check("ar_ret_depth", 32'(depth), 0);

    // Underflow
    do_ret();
    check("unf_flag", 32'(err_unf), 1);
    check("unf_thr", 32'(threshold), 0);
    check("unf_depth", 32'(depth), 0);

    // Set wins over same-cycle clear
    prio_cfg[3] = 3'd2; enable_cfg[3] = 1'b1;
    pulse_pend(3);
    tick();
    check("sc_idx", 32'(irq_index), 3);
    irq_ack = 1'b1; pend_set[3] = 1'b1;
    tick();
    irq_ack = 1'b0; pend_set = '0;
    check("sc_pend3", 32'(arb_pend[3]), 1);
    check("sc_thr", 32'(threshold), 2);
    tick();
    check("sc_no_req", 32'(irq_req), 0);
    do_ret();
    tick();
    check("sc_req3", 32'(irq_index), 3);
    do_ack();
    check("sc_pend3_clr", 32'(arb_pend[3]), 0);
    check("sc_depth1", 32'(depth), 1);

    // Overflow at STACK_DEPTH=2
    pulse_pend(4);
    tick();
    check("ov_idx4", 32'(irq_index), 4);
    do_ack();
    check("ov_depth2", 32'(depth), 2);
    check("ov_none", 32'(err_ovf), 0);
    prio_cfg[6] = 3'd7; enable_cfg[6] = 1'b1;
    pulse_pend(6);
    tick();
    check("ov_idx6", 32'(irq_index), 6);
    do_ack();
    check("ov_thr7", 32'(threshold), 7);
    check("ov_depth_sat", 32'(depth), 2);
    check("ov_flag", 32'(err_ovf), 1);
    do_ret();
    check("ov_pop_thr", 32'(threshold), 2);
    check("ov_pop_depth", 32'(depth), 1);

    // Async reset mid-REQ with depth 2
    pulse_pend(4);
    tick();
    do_ack();
    check("ar2_depth", 32'(depth), 2);
    pulse_pend(6);
    tick();
    check("ar2_req", 32'(irq_req), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_req", 32'(irq_req), 0);
    check("async_idx", 32'(irq_index), 0);
    check("async_thr", 32'(threshold), 0);
    check("async_depth", 32'(depth), 0);
    check("async_pend", 32'(arb_pend), 32'h80);
    check("async_errs", 32'({err_ovf, err_unf, err_proto}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_req", 32'(irq_req), 0);

    // Ack without request
    do_ack();
    check("nreq_proto", 32'(err_proto), 1);
    check("nreq_depth", 32'(depth), 0);
    check("nreq_thr", 32'(threshold), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL timeout: got running expected finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
